// File: rtl/rob_retire_unit_pkg.sv
// Shared utilities: reorder-buffer FIFO types plus the retire FSM state
// and completion-table entry layout.
package rob_retire_unit_pkg;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_level_e;

    typedef struct packed {
        logic       push;
        logic       pop;
    } fifo_ctrl_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } retire_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mispredict;
        logic [31:0] target;
    } cpl_payload_t;

    typedef struct packed {
        logic         valid;
        cpl_payload_t payload;
    } cpl_entry_t;

endpackage

// File: rtl/rob_retire_unit_completion_table.sv
// Tag-indexed completion table: CDB write port, head read port,
// single-entry clear on retire and bulk clear on flush.
module rob_completion_table
    import rob_retire_unit_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic [4:0]       wr_rd,
    input  logic             wr_reg_wr,
    input  logic             wr_mispredict,
    input  logic [31:0]      wr_target,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic [31:0]      rd_data,
    output logic [4:0]       rd_rd,
    output logic             rd_reg_wr,
    output logic             rd_mispredict,
    output logic [31:0]      rd_target,
    input  logic             clr_en,
    input  logic [TAG_W-1:0] clr_tag,
    input  logic             clr_all
);

    localparam int DEPTH = 1 << TAG_W;

    logic [DEPTH-1:0] valid_q;
    cpl_payload_t     payload_q [DEPTH];
    cpl_payload_t     rd_payload;

    // A write to the tag being cleared wins, so the entry stays valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else begin
            if (clr_en) valid_q[clr_tag] <= 1'b0;
            if (wr_en)  valid_q[wr_tag]  <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            payload_q[wr_tag] <= '{data:       wr_data,
                                   rd:         wr_rd,
                                   reg_wr:     wr_reg_wr,
                                   mispredict: wr_mispredict,
                                   target:     wr_target};
        end
    end

    assign rd_payload    = payload_q[rd_tag];
    assign rd_valid      = valid_q[rd_tag];
    assign rd_data       = rd_payload.data;
    assign rd_rd         = rd_payload.rd;
    assign rd_reg_wr     = rd_payload.reg_wr;
    assign rd_mispredict = rd_payload.mispredict;
    assign rd_target     = rd_payload.target;

endmodule

// File: rtl/rob_retire_unit.sv
// In-order retire stage: retires the ROB head once its completion has been
// recorded, writes the register file, and flushes on a mispredicted branch.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | accept CDB completions, retire at most one head per cycle
// ST_FLUSH | one-cycle flush pulse; CDB ignored, completion table wiped
module rob_retire_unit
    import rob_retire_unit_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             rob_empty,
    input  logic [TAG_W-1:0] rob_head_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic [4:0]       cdb_rd,
    input  logic             cdb_reg_wr,
    input  logic             cdb_mispredict,
    input  logic [31:0]      cdb_target,
    output logic             retire_completed,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_wdata,
    output logic [TAG_W-1:0] retire_tag,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      retired_count
);

    retire_state_e state;

    logic        head_valid;
    logic [31:0] head_data;
    logic [4:0]  head_rd;
    logic        head_reg_wr;
    logic        head_mispredict;
    logic [31:0] head_target;

    assign retire_completed = i_rst_n & (state == ST_RUN) & ~rob_empty & head_valid;

    rob_completion_table #(.TAG_W(TAG_W)) u_table (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .wr_en         (cdb_valid & (state == ST_RUN)),
        .wr_tag        (cdb_tag),
        .wr_data       (cdb_data),
        .wr_rd         (cdb_rd),
        .wr_reg_wr     (cdb_reg_wr),
        .wr_mispredict (cdb_mispredict),
        .wr_target     (cdb_target),
        .rd_tag        (rob_head_tag),
        .rd_valid      (head_valid),
        .rd_data       (head_data),
        .rd_rd         (head_rd),
        .rd_reg_wr     (head_reg_wr),
        .rd_mispredict (head_mispredict),
        .rd_target     (head_target),
        .clr_en        (retire_completed),
        .clr_tag       (rob_head_tag),
        .clr_all       (state == ST_FLUSH)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_RUN;
            rf_we         <= 1'b0;
            rf_rd         <= '0;
            rf_wdata      <= '0;
            retire_tag    <= '0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
            retired_count <= '0;
        end else begin
            rf_we <= 1'b0;
            flush <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (retire_completed) begin
                        rf_we         <= head_reg_wr & (head_rd != 5'd0);
                        rf_rd         <= head_rd;
                        rf_wdata      <= head_data;
                        retire_tag    <= rob_head_tag;
                        retired_count <= retired_count + 32'd1;
                        // The branch still commits its own write before the flush.
                        if (head_mispredict) begin
                            flush       <= 1'b1;
                            redirect_pc <= head_target;
                            state       <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
